// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - write-behind store buffer with youngest-match load forwarding
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [31:0]              ALUOutM,
    input  logic [31:0]              WriteDataM,
    input  logic                     MemWriteM,
    input  logic                     MemReadM,
    input  logic                     FlushM,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_we,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              ReadDataM,
    output logic                     FwdHitM,
    output logic                     SbEmpty,
    output logic [$clog2(DEPTH):0]   SbCount
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          push;
    logic          drain;
    logic [PW-1:0] idx;

    assign full    = (count_q == CW'(DEPTH));
    assign SbEmpty = (count_q == '0);
    assign SbCount = count_q;
    assign push    = MemWriteM;
    // A store into a full buffer retires the head in the same cycle, so no stall is needed.
    assign drain   = !SbEmpty && !MemReadM && (FlushM || full || !MemWriteM);

    always_comb begin
        mem_addr  = ALUOutM;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (!MemReadM && drain) begin
            mem_addr  = addr_q[head_q];
            mem_wdata = data_q[head_q];
            mem_we    = 1'b1;
        end
    end

    // Walk oldest to youngest so the last match (closest to tail-1) wins.
    always_comb begin
        FwdHitM   = 1'b0;
        ReadDataM = mem_rdata;
        idx       = head_q;
        if (MemReadM) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + PW'(i);
                if (CW'(i) < count_q && addr_q[idx] == ALUOutM) begin
                    FwdHitM   = 1'b1;
                    ReadDataM = data_q[idx];
                end
            end
        end
    end

    always_comb begin
        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = push  ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_q] <= ALUOutM;
            data_q[tail_q] <= WriteDataM;
        end
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Write-behind store buffer between the M-stage pipeline signals and the data memory. Stores from the pipeline are queued in a small FIFO and drained to memory in cycles where the memory port is not needed by a load. Loads that hit a buffered address get the youngest buffered data, so program order is preserved. The buffer also drains completely on request, for fences and test checkpoints.

## Interface
- DEPTH, 4: number of buffer entries; power of two, 2..16.
- clock  in  1  pipeline clock; state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ALUOutM  in  32  M-stage word address for a load or store.
- WriteDataM  in  32  M-stage store data.
- MemWriteM  in  1  store request this cycle.
- MemReadM  in  1  load request this cycle; never asserted together with MemWriteM.
- FlushM  in  1  drain request; held until SbEmpty.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  memory read data (valid after the memory's falling-edge read).
- ReadDataM  out  32  load result returned to the pipeline.
- FwdHitM  out  1  the current load was served from the buffer.
- SbEmpty  out  1  buffer holds no entries.
- SbCount  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage:
  - DEPTH entries of {addr[31:0], data[31:0]}.
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register, 0..DEPTH.
- push = MemWriteM. It writes entry[tail] and advances tail.
- drain = !SbEmpty && !MemReadM && (FlushM || count==DEPTH || !MemWriteM). It retires entry[head] to memory and advances head.
- In an idle M-stage cycle (no load, no store) the buffer drains one entry.
- A store into a non-full buffer is queued only; no drain happens that cycle unless FlushM is asserted.
- Store while full: the head is drained and the new store is pushed in the same cycle. count stays at DEPTH. No stall is ever required.
- Count update on each rising edge:
  - push without drain: +1.
  - drain without push: -1.
  - push with drain: unchanged.
- Memory port mux (combinational):
  - MemReadM: mem_addr=ALUOutM, mem_we=0.
  - else if drain: mem_addr=entry[head].addr, mem_wdata=entry[head].data, mem_we=1.
  - else: mem_addr=ALUOutM, mem_we=0, mem_wdata=0.
- Load forwarding:
  - Compare ALUOutM (full 32 bits) against every valid entry.
  - Select the youngest match, i.e. the one closest to tail-1.
  - FwdHitM=1 on a match; ReadDataM = the matching entry's data.
  - Otherwise FwdHitM=0 and ReadDataM=mem_rdata.
  - FwdHitM=0 whenever MemReadM=0.
- Duplicate addresses are kept as separate entries. There is no coalescing; they drain in FIFO order.
- SbEmpty = (count==0). SbCount = count.

## Timing
- Reset (reset_n low, asynchronous):
  - head, tail and count are cleared, so SbEmpty=1 and SbCount=0.
  - mem_we=0 and FwdHitM=0 while reset is held.
  - Entry contents are don't-care.
- Reset in the middle of operation discards all queued stores; none are written to memory.
- mem_we, mem_addr, mem_wdata, ReadDataM and FwdHitM are combinational from the current inputs and pre-edge state.
  - The memory samples on the falling edge, mid-cycle.
  - Pointer and count update on the following rising edge.
- A store is visible to forwarding from the cycle after its push edge.
- A store reaches memory no earlier than the cycle after its push, at the falling edge of its drain cycle.
- Load latency is unchanged by the buffer: same cycle, both on a hit and on a miss.
- Flush: with FlushM held and no loads, an N-entry buffer empties in N cycles. SbEmpty rises after the Nth rising edge.

## Test plan
- Reset, then idle: SbEmpty=1, SbCount=0, mem_we=0. Store addr 5 data 0xAA, then one idle cycle: mem_we=1 with addr 5, data 0xAA during the idle cycle; MEM[5]=0xAA; SbEmpty=1 afterwards.
- Stores to 3, 3, 3 with data 1, 2, 3, then a load of 3: FwdHitM=1, ReadDataM=3. A load of 9: FwdHitM=0, ReadDataM=9 from memory.
- Four stores to addresses 10..13, then a fifth store to 14: memory writes addr 10 during the fifth-store cycle; SbCount stays 4. Drain the rest: memory 11..14 hold the data in order.
- Back-to-back loads with 2 entries queued: mem_we stays 0 throughout and SbCount=2 is unchanged. Once MemReadM drops, both entries drain in 2 cycles.
- Store 7 data 0x55, then assert reset_n=0 before any drain: SbCount=0 and MEM[7] is still 7.
- FlushM asserted while storing to 20 and 21 into a non-empty buffer: a drain happens every cycle; SbEmpty=1 two idle cycles after the last store.
